me_control: RTL and testbench
=============================

Name: me_control

Overview:
- Sequencer for the full-search motion estimator. Drives the 16-PE systolic array, the reference/search memory address buses, and the comparator interface (CompStart, PEready one-hot, vectorX/vectorY).
- One search runs 16 candidate rows × 256 pixel cycles, then 16 drain cycles. It sits directly upstream of the comparator and PE array.

Parameters:
- NUM_PE, 16, number of PEs; PEready/NewDist/S1S2mux width (only 16 supported).
- SRCH_DIM, 32, search-window side in pixels; sets the AddressS stride.
- DRAIN_CYC, 16, cycles after the last pixel cycle to collect the final PE results.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a search; sampled in IDLE only.
- busy  out  1  high in CLEAR, RUN and DRAIN.
- done  out  1  one-cycle pulse in DONE.
- CompStart  out  1  comparator enable; low clears BestDist.
- PEready  out  16  one-hot; bit i = PE i result valid this cycle.
- vectorX  out  4  candidate X offset matching PEready.
- vectorY  out  4  candidate Y offset matching PEready.
- NewDist  out  16  one-hot; bit i = PE i clears its accumulator this cycle.
- AddressR  out  8  reference block pixel address.
- AddressS1  out  10  search memory port 1 address.
- AddressS2  out  10  search memory port 2 address (AddressS1+16).
- S1S2mux  out  16  per-PE select; 1 = S1, 0 = S2.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, count=0, and every output is 0. CompStart=0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE. count is 13 bits.
- IDLE: start=1 → CLEAR. CompStart keeps its previous value so the last BestDist/motion stays readable. All strobes are 0.
- CLEAR (1 cycle): CompStart=0 so the comparator loads BestDist=FF. count←0. Next state is RUN.
- RUN (4096 cycles, count 0..4095):
  - CompStart=1.
  - AddressR=count[7:0].
  - AddressS1=(count[11:8]+count[7:4])*SRCH_DIM+count[3:0]; the 5-bit sum never exceeds 30.
  - AddressS2=AddressS1+16.
  - S1S2mux[i]=(count[3:0]>=i).
  - NewDist[i]=1 iff count[7:0]==i.
  - PEready[i]=1 iff count[7:0]==i and count[11:8]!=0, with vectorX=i and vectorY=count[11:8]-1.
  - At count=4095 → DRAIN.
- DRAIN (DRAIN_CYC cycles, count 4096..4111):
  - PEready[count[3:0]]=1, vectorX=count[3:0], vectorY=15.
  - NewDist=0 and addresses hold at 0.
  - At count=4111 → DONE.
- DONE (1 cycle): done=1, CompStart stays 1, then → IDLE.
- Strobe rules:
  - PEready and NewDist are strictly one-hot or all-zero. PEready is never asserted outside RUN/DRAIN.
  - vectorX/vectorY are 0 when PEready=0.
- start while busy: ignored.
- Registering: all outputs are registered, or decoded from registered count/state only; no combinational path from start to any output.
- Reset mid-search: immediate return to IDLE with all outputs 0. The next start runs a full search from count=0.
- Total latency: start sampled → done = 1+4096+16+1 = 4114 cycles.

Optional Feature:
- ME_STALL_EN defined:
  - Adds input port stall (1 bit).
  - While stall=1 in RUN or DRAIN: count and state freeze; PEready, NewDist and done are forced to 0; addresses hold.
  - Frozen strobes re-issue on the first cycle after stall deasserts.
  - stall in IDLE/CLEAR/DONE has no effect.
- Not defined: no stall port, behaviour exactly as above.

Decomposition:
- Package me_pkg:
  - state enum ME_IDLE/ME_CLEAR/ME_RUN/ME_DRAIN/ME_DONE.
  - Constants ME_NUM_PE=16, ME_RUN_LAST=4095, ME_DRAIN_LAST=4111, ME_SRCH_DIM=32.
- One sub-module, me_addr_gen: purely combinational address/S1S2mux decode from count.
- FSM and counter stay in me_control.

Test Plan:
- Reset: assert reset_n=0 mid-RUN at count=1000 → all outputs 0 immediately; state=IDLE; restart produces AddressR=0 on first RUN cycle.
- Full search: start pulse.
  - CompStart=0 exactly one cycle, then 1.
  - done exactly 4114 cycles after start.
  - 256 PEready pulses total, each one-hot.
  - Last pulse: PEready=16'h8000, vectorX=15, vectorY=15.
- Row boundary: at count=256 → PEready=16'h0001, vectorX=0, vectorY=0, NewDist=16'h0001. At count=271 → PEready=16'h8000.
- Address decode:
  - count=0x0F3 → AddressR=0xF3, AddressS1=15*32+3=483, AddressS2=499, S1S2mux=16'h000F.
  - count=0xFFF → AddressS1=30*32+15=975.
- start ignored: start held high through the whole search → no restart; done once; returns to IDLE with CompStart=1.
- ME_STALL_EN: stall=1 for 5 cycles at count=300 → count stays 300, PEready=0 during stall; done delayed by exactly 5 cycles.

Source files
------------

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared states, constants and helpers for the motion-estimator sequencer
package me_pkg;

   typedef enum logic [2:0] {
      ME_IDLE,
      ME_CLEAR,
      ME_RUN,
      ME_DRAIN,
      ME_DONE
   } me_state_e;

   localparam int          ME_NUM_PE     = 16;
   localparam int          ME_SRCH_DIM   = 32;
   localparam logic [12:0] ME_RUN_LAST   = 13'd4095;
   localparam logic [12:0] ME_DRAIN_LAST = 13'd4111;

   function automatic logic [ME_NUM_PE-1:0] me_onehot(input logic [3:0] idx);
      logic [ME_NUM_PE-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/me_addr_gen.sv
// rtl/me_addr_gen.sv - reference/search address and S1/S2 select decode from the search count
module me_addr_gen
   import me_pkg::*;
#(
   parameter int SRCH_DIM = ME_SRCH_DIM
) (
   input  logic                 run_i,
   input  logic [11:0]          count_i,
   output logic [7:0]           addr_r_o,
   output logic [9:0]           addr_s1_o,
   output logic [9:0]           addr_s2_o,
   output logic [ME_NUM_PE-1:0] s1s2_mux_o
);

   logic [9:0] row_sum;
   logic [9:0] s1_addr;

   // candidate row plus pixel row never exceeds 30, so the product fits in 10 bits
   assign row_sum = 10'(count_i[11:8]) + 10'(count_i[7:4]);
   assign s1_addr = row_sum * 10'(SRCH_DIM) + 10'(count_i[3:0]);

   always_comb begin
      addr_r_o   = '0;
      addr_s1_o  = '0;
      addr_s2_o  = '0;
      s1s2_mux_o = '0;
      if (run_i) begin
         addr_r_o  = count_i[7:0];
         addr_s1_o = s1_addr;
         addr_s2_o = s1_addr + 10'(ME_NUM_PE);
         for (int i = 0; i < ME_NUM_PE; i++) begin
            s1s2_mux_o[i] = (count_i[3:0] >= 4'(i));
         end
      end
   end

endmodule

// File: rtl/me_control.sv
// rtl/me_control.sv - full-search motion estimator sequencer (PE array, memories, comparator)
// Optional stall input when ME_STALL_EN is defined.
module me_control
   import me_pkg::*;
#(
   parameter int NUM_PE    = ME_NUM_PE,
   parameter int SRCH_DIM  = ME_SRCH_DIM,
   parameter int DRAIN_CYC = int'(ME_DRAIN_LAST - ME_RUN_LAST)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
`ifdef ME_STALL_EN
   input  logic              stall,
`endif
   output logic              busy,
   output logic              done,
   output logic              CompStart,
   output logic [NUM_PE-1:0] PEready,
   output logic [3:0]        vectorX,
   output logic [3:0]        vectorY,
   output logic [NUM_PE-1:0] NewDist,
   output logic [7:0]        AddressR,
   output logic [9:0]        AddressS1,
   output logic [9:0]        AddressS2,
   output logic [NUM_PE-1:0] S1S2mux
);

   localparam logic [12:0] DRAIN_LAST = ME_RUN_LAST + 13'(DRAIN_CYC);

   me_state_e   state_q, state_d;
   logic [12:0] count_q, count_d;
   logic        busy_q, done_q, comp_start_q;
   logic        stall_w;
   logic        frozen;

`ifdef ME_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   assign frozen = stall_w && (state_q == ME_RUN || state_q == ME_DRAIN);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         ME_IDLE: begin
            if (start) state_d = ME_CLEAR;
         end
         ME_CLEAR: begin
            count_d = '0;
            state_d = ME_RUN;
         end
         ME_RUN: begin
            if (!frozen) begin
               count_d = count_q + 13'd1;
               if (count_q == ME_RUN_LAST) state_d = ME_DRAIN;
            end
         end
         ME_DRAIN: begin
            if (!frozen) begin
               count_d = count_q + 13'd1;
               if (count_q == DRAIN_LAST) state_d = ME_DONE;
            end
         end
         ME_DONE: begin
            count_d = '0;
            state_d = ME_IDLE;
         end
         default: begin
            count_d = '0;
            state_d = ME_IDLE;
         end
      endcase
   end

   // status outputs are registered from the next state so they line up with state_q
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ME_IDLE;
         count_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         comp_start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= (state_d == ME_CLEAR) || (state_d == ME_RUN) || (state_d == ME_DRAIN);
         done_q  <= (state_d == ME_DONE);
         if (state_d == ME_CLEAR)    comp_start_q <= 1'b0;
         else if (state_d == ME_RUN) comp_start_q <= 1'b1;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign CompStart = comp_start_q;

   always_comb begin
      PEready = '0;
      NewDist = '0;
      vectorX = '0;
      vectorY = '0;
      if (state_q == ME_RUN && !frozen && count_q[7:4] == 4'd0) begin
         NewDist = me_onehot(count_q[3:0]);
         // row 0 has no previous candidate to report yet
         if (count_q[11:8] != 4'd0) begin
            PEready = me_onehot(count_q[3:0]);
            vectorX = count_q[3:0];
            vectorY = count_q[11:8] - 4'd1;
         end
      end else if (state_q == ME_DRAIN && !frozen) begin
         PEready = me_onehot(count_q[3:0]);
         vectorX = count_q[3:0];
         vectorY = 4'hF;
      end
   end

   me_addr_gen #(
      .SRCH_DIM (SRCH_DIM)
   ) u_addr_gen (
      .run_i      (state_q == ME_RUN),
      .count_i    (count_q[11:0]),
      .addr_r_o   (AddressR),
      .addr_s1_o  (AddressS1),
      .addr_s2_o  (AddressS2),
      .s1s2_mux_o (S1S2mux)
   );

endmodule

// File: tb/tb_me_control.sv
// tb/tb_me_control.sv - self-checking bench for me_control (stall checks when ME_STALL_EN is defined)
module tb_me_control;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        cs;
      logic [15:0] pe;
      logic [3:0]  vx;
      logic [3:0]  vy;
      logic [15:0] nd;
      logic [7:0]  ar;
      logic [9:0]  s1;
      logic [9:0]  s2;
      logic [15:0] mux;
   } out_t;

   typedef struct {
      int   pos;
      out_t exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stall;
   logic        stall_next;
   logic        busy, done, CompStart;
   logic [15:0] PEready, NewDist, S1S2mux;
   logic [3:0]  vectorX, vectorY;
   logic [7:0]  AddressR;
   logic [9:0]  AddressS1, AddressS2;
   out_t        act;
   out_t        cap [0:4111];
   vec_t        tbl [8];
   logic        comp_exp;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clock = ~clock;

   me_control dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
`ifdef ME_STALL_EN
      .stall     (stall),
`endif
      .busy      (busy),
      .done      (done),
      .CompStart (CompStart),
      .PEready   (PEready),
      .vectorX   (vectorX),
      .vectorY   (vectorY),
      .NewDist   (NewDist),
      .AddressR  (AddressR),
      .AddressS1 (AddressS1),
      .AddressS2 (AddressS2),
      .S1S2mux   (S1S2mux)
   );

   assign act = {busy, done, CompStart, PEready, vectorX, vectorY, NewDist,
                 AddressR, AddressS1, AddressS2, S1S2mux};

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // reference: search position -> outputs, straight from the row/pixel arithmetic
   function automatic out_t model(input int pos, input bit stalled);
      out_t e;
      int   row, pix, px, py;
      e      = '0;
      e.busy = 1'b1;
      e.cs   = 1'b1;
      if (pos < 4096) begin
         row  = pos / 256;
         pix  = pos % 256;
         py   = pix / 16;
         px   = pix % 16;
         e.ar = 8'(pix);
         e.s1 = 10'((row + py) * 32 + px);
         e.s2 = 10'((row + py) * 32 + px + 16);
         for (int i = 0; i < 16; i++) e.mux[i] = (px >= i);
         if (!stalled && pix < 16) begin
            e.nd[pix] = 1'b1;
            if (row > 0) begin
               e.pe[pix] = 1'b1;
               e.vx      = 4'(pix);
               e.vy      = 4'(row - 1);
            end
         end
      end else if (!stalled) begin
         e.pe[pos - 4096] = 1'b1;
         e.vx             = 4'(pos - 4096);
         e.vy             = 4'd15;
      end
      return e;
   endfunction

   function automatic out_t mk(input int pe, input int vx, input int vy, input int nd,
                               input int ar, input int s1, input int s2, input int mux);
      out_t e;
      e      = '0;
      e.busy = 1'b1;
      e.cs   = 1'b1;
      e.pe   = 16'(pe);
      e.vx   = 4'(vx);
      e.vy   = 4'(vy);
      e.nd   = 16'(nd);
      e.ar   = 8'(ar);
      e.s1   = 10'(s1);
      e.s2   = 10'(s2);
      e.mux  = 16'(mux);
      return e;
   endfunction

   task automatic idle_check(input int n, input string name);
      out_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         e    = '0;
         e.cs = comp_exp;
         check(name, act, e);
      end
   endtask

   task automatic run_search(input int hold, input int reset_at, input int stall_at,
                             input int stall_len, input bit capture,
                             output int lat, output int pulses);
      int   k, pos, stall_left;
      bit   fin, cur_stall, stall_used;
      out_t e;
      lat = -1; pulses = 0; k = 0; pos = 0; fin = 0; stall_left = 0; stall_used = 0;
      stall_next = 1'b0;
      @(negedge clock);
      start = 1'b1;
      while (!fin && k < 9000) begin
         @(posedge clock);
         #1 stall = stall_next;
         @(negedge clock);
         k++;
         cur_stall = stall;
         if (k == 1) begin
            e      = '0;
            e.busy = 1'b1;
            check("clear cycle", act, e);
         end else if (pos < 4112) begin
            e = model(pos, cur_stall);
            check($sformatf("search pos=%0d cyc=%0d stall=%0d", pos, k, cur_stall), act, e);
            if (!cur_stall) begin
               if (PEready != 16'd0) begin
                  pulses++;
                  check("PEready one-hot", 128'($onehot(PEready)), 128'd1);
               end
               if (capture) cap[pos] = act;
            end
            if (pos == reset_at) begin
               reset_n    = 1'b0;
               start      = 1'b0;
               stall      = 1'b0;
               stall_next = 1'b0;
               #1 check("reset mid-search outputs", act, 128'd0);
               comp_exp = 1'b0;
               @(negedge clock);
               check("reset held outputs", act, 128'd0);
               reset_n = 1'b1;
               fin     = 1'b1;
            end else if (!cur_stall) begin
               pos++;
            end
         end else begin
            e      = '0;
            e.done = 1'b1;
            e.cs   = 1'b1;
            check("done cycle", act, e);
            lat      = k;
            comp_exp = 1'b1;
            fin      = 1'b1;
         end
         if (k == hold) start = 1'b0;
         if (!fin) begin
            if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) stall_next = 1'b0;
            end else if (!stall_used && stall_len > 0 && pos == stall_at && k > 1) begin
               stall_next = 1'b1;
               stall_left = stall_len;
               stall_used = 1'b1;
            end
         end
      end
      if (!fin) check("search finished within bound", 128'd0, 128'd1);
      start      = 1'b0;
      stall      = 1'b0;
      stall_next = 1'b0;
   endtask

   initial begin
      int lat, pulses, hold, rst_at, s_at, s_len;

      tbl[0] = '{0,    mk(0,       0,  0,  16'h0001, 8'h00, 0,   16,  16'h0001)};
      tbl[1] = '{243,  mk(0,       0,  0,  0,        8'hF3, 483, 499, 16'h000F)};
      tbl[2] = '{256,  mk(16'h0001, 0,  0,  16'h0001, 8'h00, 32,  48,  16'h0001)};
      tbl[3] = '{271,  mk(16'h8000, 15, 0,  16'h8000, 8'h0F, 47,  63,  16'hFFFF)};
      tbl[4] = '{3840, mk(16'h0001, 0,  14, 16'h0001, 8'h00, 480, 496, 16'h0001)};
      tbl[5] = '{4095, mk(0,       0,  0,  0,        8'hFF, 975, 991, 16'hFFFF)};
      tbl[6] = '{4096, mk(16'h0001, 0,  15, 0,        0,     0,   0,   0)};
      tbl[7] = '{4111, mk(16'h8000, 15, 15, 0,        0,     0,   0,   0)};

      reset_n    = 1'b0;
      start      = 1'b0;
      stall      = 1'b0;
      stall_next = 1'b0;
      comp_exp   = 1'b0;
      idle_check(2, "reset state");
      reset_n = 1'b1;
      idle_check(2, "idle after reset");

      run_search(1, 1000, -1, 0, 1'b0, lat, pulses);
      idle_check(2, "idle after reset mid-search");

      run_search(1, -1, -1, 0, 1'b1, lat, pulses);
      check("latency start->done", 128'(lat), 128'd4114);
      check("PEready pulse count", 128'(pulses), 128'd256);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("vector pos=%0d", tbl[i].pos), cap[tbl[i].pos], tbl[i].exp);
      end
      idle_check(3, "idle keeps CompStart");

      run_search(4114, -1, -1, 0, 1'b0, lat, pulses);
      check("latency start held", 128'(lat), 128'd4114);
      idle_check(20, "no restart after held start");

`ifdef ME_STALL_EN
      stall = 1'b1;
      idle_check(3, "stall in idle");
      stall = 1'b0;
      run_search(1, -1, 300, 5, 1'b0, lat, pulses);
      check("latency with 5-cycle stall", 128'(lat), 128'd4119);
      check("pulse count with stall", 128'(pulses), 128'd256);
      idle_check(2, "idle after stalled search");
`endif

      for (int r = 0; r < 4; r++) begin
         idle_check($urandom_range(0, 12), "random idle gap");
         hold   = $urandom_range(1, 40);
         rst_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4111)) : -1;
         s_at   = -1;
         s_len  = 0;
`ifdef ME_STALL_EN
         s_at  = $urandom_range(1, 4111);
         s_len = $urandom_range(1, 8);
`endif
         run_search(hold, rst_at, s_at, s_len, 1'b0, lat, pulses);
         if (rst_at < 0) begin
            check("random search latency", 128'(lat), 128'(4114 + s_len));
            check("random search pulses", 128'(pulses), 128'd256);
         end
         idle_check(2, "idle after random search");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
